// File: rtl/fifo_burst_reader.sv
// Read-side burst master for sync_fifo: pops the FIFO over its valid/ready port and
// re-emits words downstream as framed bursts (full, flushed, or idle-timeout partial).
module fifo_burst_reader #(
    parameter int FIFO_DEPTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int BURST_LEN  = 4,
    parameter int TIMEOUT    = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid_m,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH:0]   i_fill_lvl,
    output logic                  o_ready_m,
    input  logic                  i_flush,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic [15:0]           o_burst_count
);
    localparam int LVL_W  = ADDR_WIDTH + 1;
    localparam int BEAT_W = $clog2(BURST_LEN + 1);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(BURST_LEN);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t                state_r, state_s;
    logic [BEAT_W-1:0]     beats_r, beats_s;
    logic [TO_W-1:0]       idle_cnt_r, idle_cnt_s;
    logic [LVL_W-1:0]      len_s;
    logic                  start_s;
    logic                  pop_s;
    logic                  valid_s;
    logic [DATA_WIDTH-1:0] data_s;
    logic                  last_s;
    logic                  busy_s;
    logic [15:0]           count_s;

    // A single output register: a pop is allowed whenever it is empty or being drained.
    assign o_ready_m = (state_r == BURST) && (beats_r != {BEAT_W{1'b0}}) && (!o_valid || i_ready);

    // Next-state, burst length selection, idle timeout and output-stage update.
    always_comb begin
        state_s    = state_r;
        beats_s    = beats_r;
        idle_cnt_s = idle_cnt_r;
        len_s      = {LVL_W{1'b0}};
        start_s    = 1'b0;
        valid_s    = o_valid;
        data_s     = o_data;
        last_s     = o_last;
        pop_s      = o_ready_m && i_valid_m;

        case (state_r)
            IDLE: begin
                // Below the full threshold the buffered level is already the min() length.
                if (i_fill_lvl >= FULL_LVL) begin
                    start_s = 1'b1;
                    len_s   = FULL_LVL;
                end else if (i_flush && (i_fill_lvl != {LVL_W{1'b0}})) begin
                    start_s = 1'b1;
                    len_s   = i_fill_lvl;
                end else if ((idle_cnt_r == TO_LAST) && (i_fill_lvl != {LVL_W{1'b0}})) begin
                    start_s = 1'b1;
                    len_s   = i_fill_lvl;
                end else begin
                    start_s = 1'b0;
                end

                if (start_s) begin
                    state_s    = BURST;
                    beats_s    = len_s[BEAT_W-1:0];
                    idle_cnt_s = {TO_W{1'b0}};
                end else if (i_fill_lvl == {LVL_W{1'b0}}) begin
                    idle_cnt_s = {TO_W{1'b0}};
                end else begin
                    idle_cnt_s = idle_cnt_r + TO_W'(1);
                end
            end
            BURST: begin
                idle_cnt_s = {TO_W{1'b0}};
                if (pop_s) begin
                    beats_s = beats_r - BEAT_W'(1);
                    if (beats_r == BEAT_W'(1)) begin
                        state_s = IDLE;
                    end else begin
                        state_s = BURST;
                    end
                end else begin
                    beats_s = beats_r;
                end
            end
            default: begin
                state_s    = IDLE;
                beats_s    = {BEAT_W{1'b0}};
                idle_cnt_s = {TO_W{1'b0}};
            end
        endcase

        if (pop_s) begin
            valid_s = 1'b1;
            data_s  = i_data;
            last_s  = (beats_r == BEAT_W'(1));
        end else if (o_valid && i_ready) begin
            valid_s = 1'b0;
            last_s  = 1'b0;
        end else begin
            valid_s = o_valid;
        end

        count_s = o_burst_count + 16'(start_s);
        busy_s  = (state_s == BURST) || valid_s;
    end

    // State, counters and registered downstream outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r       <= IDLE;
            beats_r       <= {BEAT_W{1'b0}};
            idle_cnt_r    <= {TO_W{1'b0}};
            o_valid       <= 1'b0;
            o_data        <= {DATA_WIDTH{1'b0}};
            o_last        <= 1'b0;
            o_busy        <= 1'b0;
            o_burst_count <= 16'd0;
        end else begin
            state_r       <= state_s;
            beats_r       <= beats_s;
            idle_cnt_r    <= idle_cnt_s;
            o_valid       <= valid_s;
            o_data        <= data_s;
            o_last        <= last_s;
            o_busy        <= busy_s;
            o_burst_count <= count_s;
        end
    end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Bench for fifo_burst_reader: a small behavioural sync FIFO feeds the DUT; a per-cycle
// vector table covers burst framing and stalls, hand sequences cover reset/timeout/flush.
module tb_fifo_burst_reader;
    logic        clk = 1'b0;
    logic        rst, valid_m, ready_m, flush, o_valid, o_last, rdy, busy;
    logic [7:0]  fifo_data, o_data, push_data;
    logic [4:0]  fill_lvl, wr, rd;
    logic [15:0] cnt;
    logic        push_en, fifo_clr;
    logic [7:0]  mem [16];

    int checks = 0;
    int errors = 0;
    int got_n;
    int idle;
    logic [7:0] got_data [8];
    logic       got_last [8];

    typedef struct {
        logic        push;
        logic [7:0]  pdata;
        logic        rdy;
        logic        ev;
        logic [7:0]  ed;
        logic        el;
        logic        erm;
        logic        eb;
        logic [15:0] ecnt;
    } vec_t;
    vec_t vecs [23];

    always #5 clk = ~clk;

    fifo_burst_reader dut (
        .i_clk(clk), .i_rst(rst), .i_valid_m(valid_m), .i_data(fifo_data),
        .i_fill_lvl(fill_lvl), .o_ready_m(ready_m), .i_flush(flush),
        .o_valid(o_valid), .o_data(o_data), .o_last(o_last), .i_ready(rdy),
        .o_busy(busy), .o_burst_count(cnt)
    );

    // Behavioural sync FIFO: level is wr - rd, so it reflects a pop one cycle later.
    always_ff @(posedge clk) begin
        if (fifo_clr) begin
            wr <= 5'd0;
            rd <= 5'd0;
        end else begin
            if (push_en) begin
                mem[wr[3:0]] <= push_data;
                wr <= wr + 5'd1;
            end
            if (valid_m && ready_m) rd <= rd + 5'd1;
        end
    end
    assign fill_lvl  = wr - rd;
    assign valid_m   = (fill_lvl != 5'd0);
    assign fifo_data = mem[rd[3:0]];

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s [%0d]: got %0h expected %0h", name, idx, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; fifo_clr = 1'b1; push_en = 1'b0; flush = 1'b0; rdy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0; fifo_clr = 1'b0;
        #1;
    endtask

    task automatic push_words(input int n, input logic [7:0] base, input logic fl);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            push_en = 1'b1;
            push_data = base + 8'(i);
        end
        @(negedge clk);
        push_en = 1'b0;
        flush = fl;
        #1;
    endtask

    // Records downstream transfers (i_ready held high) until n beats seen or budget expires.
    task automatic collect(input int n, input int budget);
        int cyc = 0;
        got_n = 0;
        for (int i = 0; i < 8; i++) begin
            got_data[i] = 8'h00;
            got_last[i] = 1'b0;
        end
        while (got_n < n && cyc < budget) begin
            if (o_valid && rdy) begin
                got_data[got_n] = o_data;
                got_last[got_n] = o_last;
                got_n++;
            end
            if (got_n < n) begin
                @(negedge clk);
                #1;
                cyc++;
            end
        end
        chk("collect_beats", n, got_n, n);
    endtask

    task automatic chk_burst(input string name, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            chk({name, "_data"}, i, got_data[i], base + 8'(i));
            chk({name, "_last"}, i, got_last[i], (i == n - 1) ? 1 : 0);
        end
    endtask

    initial begin
        rst = 1'b1; fifo_clr = 1'b1; push_en = 1'b0; push_data = 8'h00; flush = 1'b0; rdy = 1'b1;

        //                push  pdata  rdy  ev   ed     el   erm  eb   cnt
        vecs[0]  = '{1'b1, 8'hA0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[1]  = '{1'b1, 8'hA1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[2]  = '{1'b1, 8'hA2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[3]  = '{1'b1, 8'hA3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd0};
        vecs[5]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[6]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA0, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[7]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA1, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA2, 1'b0, 1'b1, 1'b1, 16'd1};
        vecs[9]  = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA3, 1'b1, 1'b0, 1'b1, 16'd1};
        vecs[10] = '{1'b1, 8'hB0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[11] = '{1'b1, 8'hB1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[12] = '{1'b1, 8'hB2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[13] = '{1'b1, 8'hB3, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1};
        vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'd2};
        vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB0, 1'b0, 1'b1, 1'b1, 16'd2};
        vecs[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[18] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0, 1'b0, 1'b1, 16'd2};
        vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB1, 1'b0, 1'b1, 1'b1, 16'd2};
        vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB2, 1'b0, 1'b1, 1'b1, 16'd2};
        vecs[21] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hB3, 1'b1, 1'b0, 1'b1, 16'd2};
        vecs[22] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2};

        // Reset held while the FIFO fills: outputs stay 0, no pop until one cycle after release.
        @(negedge clk);
        @(negedge clk);
        fifo_clr = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            push_en = 1'b1;
            push_data = 8'hC0 + 8'(i);
            #1;
            chk("rst_valid", i, o_valid, 0);
            chk("rst_last", i, o_last, 0);
            chk("rst_data", i, o_data, 0);
            chk("rst_ready_m", i, ready_m, 0);
            chk("rst_busy", i, busy, 0);
            chk("rst_count", i, cnt, 0);
        end
        @(negedge clk);
        push_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("post_rst_ready_m", 0, ready_m, 0);
        @(negedge clk);
        #1;
        chk("post_rst_ready_m", 1, ready_m, 1);
        chk("post_rst_count", 1, cnt, 1);
        collect(4, 20);
        chk_burst("post_rst", 4, 8'hC0);

        // Table: full burst at threshold, then a burst with i_ready pattern 1,0,0,1.
        do_reset();
        for (int i = 0; i < 23; i++) begin
            @(negedge clk);
            push_en = vecs[i].push;
            push_data = vecs[i].pdata;
            rdy = vecs[i].rdy;
            #1;
            chk("tbl_valid", i, o_valid, vecs[i].ev);
            if (vecs[i].ev) begin
                chk("tbl_data", i, o_data, vecs[i].ed);
                chk("tbl_last", i, o_last, vecs[i].el);
            end
            chk("tbl_ready_m", i, ready_m, vecs[i].erm);
            chk("tbl_busy", i, busy, vecs[i].eb);
            chk("tbl_count", i, cnt, vecs[i].ecnt);
        end
        @(negedge clk);
        push_en = 1'b0;
        rdy = 1'b1;

        // Two words, no flush: 32 idle cycles with non-zero level before the partial burst.
        do_reset();
        @(negedge clk);
        push_en = 1'b1;
        push_data = 8'hD0;
        #1;
        @(negedge clk);
        push_data = 8'hD1;
        #1;
        idle = 0;
        while (!ready_m && idle < 100) begin
            idle++;
            @(negedge clk);
            push_en = 1'b0;
            #1;
        end
        push_en = 1'b0;
        chk("timeout_idle", 0, idle, 32);
        collect(2, 20);
        chk_burst("timeout", 2, 8'hD0);
        chk("timeout_count", 0, cnt, 1);

        // Three words plus flush: burst of 3 starts on the next cycle.
        do_reset();
        push_words(3, 8'hE0, 1'b1);
        chk("flush_ready_m", 0, ready_m, 0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        chk("flush_ready_m", 1, ready_m, 1);
        collect(3, 20);
        chk_burst("flush3", 3, 8'hE0);
        chk("flush_count", 0, cnt, 1);

        // Six words with flush coinciding with the full threshold: burst of 4, rest times out.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            push_en = 1'b1;
            push_data = 8'hF0 + 8'(i);
            flush = (i == 4);
        end
        @(negedge clk);
        push_en = 1'b0;
        flush = 1'b0;
        #1;
        collect(4, 20);
        chk_burst("full4", 4, 8'hF0);
        @(negedge clk);
        #1;
        idle = 0;
        while (!ready_m && idle < 100) begin
            idle++;
            @(negedge clk);
            #1;
        end
        chk("rest_idle", 0, idle, 31);
        collect(2, 20);
        chk_burst("rest2", 2, 8'hF4);
        chk("rest_count", 0, cnt, 2);

        // Reset after two of four beats; a fresh push then produces a clean burst.
        do_reset();
        push_words(4, 8'h10, 1'b0);
        @(negedge clk);
        #1;
        chk("mid_ready_m", 0, ready_m, 1);
        @(negedge clk);
        #1;
        chk("mid_data", 0, o_data, 8'h10);
        @(negedge clk);
        rst = 1'b1;
        fifo_clr = 1'b1;
        #1;
        @(negedge clk);
        rst = 1'b0;
        fifo_clr = 1'b0;
        #1;
        chk("mid_valid", 0, o_valid, 0);
        chk("mid_count", 0, cnt, 0);
        chk("mid_busy", 0, busy, 0);
        chk("mid_ready_m", 1, ready_m, 0);
        push_words(4, 8'h20, 1'b0);
        collect(4, 20);
        chk_burst("clean", 4, 8'h20);
        chk("clean_count", 0, cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
